vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Raster timing generator for the VGA/DVI output path, in the pixel clock domain.
//  Holds the display idle until the DAC I2C init sequence reports done.
//  Then produces HSync, VSync and DE, the pixel X/Y position, and a next-line fetch pulse for the NPI line reader.
//  Sits downstream of the DAC init block (consumes its Done) and beside the line buffer.
// PARAMETERS
//  H_ACTIVE   640  visible pixels per line
//  H_FP       16   horizontal front porch, pixels
//  H_SYNC     96   hsync width, pixels
//  H_BP       48   horizontal back porch, pixels
//  V_ACTIVE   480  visible lines per frame
//  V_FP       10   vertical front porch, lines
//  V_SYNC     2    vsync width, lines
//  V_BP       33   vertical back porch, lines
//  HS_POL     0    active level of HSync
//  VS_POL     0    active level of VSync
//  CNT_W      12   width of counters and X/Y
// PORTS
//  Clk          in   1      pixel clock
//  Reset_n      in   1      synchronous, active-low reset
//  Init_done    in   1      level; DAC init complete (Done of the I2C init block)
//  HSync        out  1      horizontal sync, registered
//  VSync        out  1      vertical sync, registered
//  DE           out  1      data enable, high on active pixels
//  X            out  CNT_W  pixel column, valid while DE
//  Y            out  CNT_W  pixel row, valid while DE
//  Frame_start  out  1      1-cycle pulse with pixel (0,0)
//  Line_fetch   out  1      1-cycle pulse requesting the next active line
//  Fetch_line   out  CNT_W  row index of the line requested; held between pulses
// BEHAVIOUR
//  - Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
//  - h_cnt runs 0..H_TOTAL-1 and wraps to 0; v_cnt increments on that h wrap.
//  - Regions: [0,ACTIVE) active, then FP, SYNC, BP.
//  - Top FSM states:
//      WAIT_INIT: counters held at 0; all outputs idle.
//      RUN: counters free-run.
//      DRAIN: counters free-run; entered when Init_done falls during RUN.
//  - Transitions:
//      WAIT_INIT->RUN: on the cycle after Init_done is sampled high; that cycle has h=0, v=0.
//      DRAIN->WAIT_INIT: at the end of the last frame cycle (h=H_TOTAL-1, v=V_TOTAL-1).
//      DRAIN->RUN: if Init_done returns high before the frame end; the frame is never truncated.
//  - Outputs are registered from counter state: 1-cycle latency, with all outputs mutually aligned.
//  - HSync = HS_POL while h is in the SYNC region, else ~HS_POL. VSync = VS_POL while v is in its SYNC region (whole lines), else ~VS_POL.
//  - DE = (h < H_ACTIVE) && (v < V_ACTIVE) && state != WAIT_INIT.
//  - X/Y equal h/v while DE=1 and are held at their last values otherwise.
//  - Frame_start fires when h=0 and v=0 in RUN or DRAIN.
//  - Line_fetch fires when h == H_ACTIVE on line v in {V_TOTAL-1, 0..V_ACTIVE-2}.
//    Fetch_line = (v == V_TOTAL-1) ? 0 : v+1, so a fetch leads its line by one line period.
//  - Reset values: HSync=~HS_POL, VSync=~VS_POL, DE=0, X=0, Y=0, Frame_start=0, Line_fetch=0, Fetch_line=0, state=WAIT_INIT.
//    Reset mid-frame aborts immediately, on the next edge.
//  - Widths: all comparisons are CNT_W unsigned. Elaboration fails if H_TOTAL or V_TOTAL exceeds 2**CNT_W.
// CONFIGURATION
//  - COLOR_BAR_EN defined:
//      Adds outputs Red, Green, Blue (8 bits each), registered and aligned with DE.
//      Pattern: 8 vertical bars, each H_ACTIVE/8 wide, in the order white, yellow, cyan, green, magenta, red, blue, black.
//      All three outputs are 0 when DE=0 and at reset.
//  - COLOR_BAR_EN undefined: the colour ports and logic are absent.
// STRUCTURE
//  - Package vga_timing_pkg: top-state enum (WAIT_INIT/RUN/DRAIN), region enum (ACTIVE/FP/SYNC/BP), 640x480@60 default constants.
//  - One sub-module, vga_axis_counter, instantiated for H and V.
//      Parameters: ACTIVE/FP/SYNC/BP.
//      Inputs: enable and clear. Outputs: count, region, wrap.
//  - The top level holds the FSM, output registers and the optional colour bars.
// TESTING
//  1. Reset, Init_done=0 for 2000 cycles -> DE=0, HSync=VSync=1, no pulses.
//  2. Raise Init_done -> Frame_start one cycle later with DE=1, X=0, Y=0.
//     Then 640 DE cycles per line and HSync low for exactly 96 cycles, starting 16 cycles after DE falls.
//  3. Run 2 frames -> 525 lines of 800 cycles each; VSync low for 1600 cycles; 480 Line_fetch pulses per frame.
//     The first Line_fetch of a frame comes on v=524 with Fetch_line=0.
//  4. Drop Init_done at v=100 -> the frame completes to v=524, h=799.
//     DE is then 0 from the next cycle, and no new Frame_start occurs.
//  5. Assert Reset_n=0 at h=300, v=200 -> all outputs are at reset values on the next cycle.
//  6. COLOR_BAR_EN: at X=0/80/560 -> RGB = FFFFFF / FFFF00 / 000000; RGB = 0 during blanking.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared enums and 640x480@60 default timing for the VGA raster generator.
package vga_timing_pkg;

    typedef enum logic [1:0] {WAIT_INIT, RUN, DRAIN} state_t;
    typedef enum logic [1:0] {REG_ACTIVE, REG_FP, REG_SYNC, REG_BP} region_t;

    localparam int   DEF_H_ACTIVE = 640;
    localparam int   DEF_H_FP     = 16;
    localparam int   DEF_H_SYNC   = 96;
    localparam int   DEF_H_BP     = 48;
    localparam int   DEF_V_ACTIVE = 480;
    localparam int   DEF_V_FP     = 10;
    localparam int   DEF_V_SYNC   = 2;
    localparam int   DEF_V_BP     = 33;
    localparam logic DEF_HS_POL   = 1'b0;
    localparam logic DEF_VS_POL   = 1'b0;
    localparam int   DEF_CNT_W    = 12;

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis; counts 0..TOTAL-1, reports its region and terminal count.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    parameter int CNT_W  = DEF_CNT_W
)(
    input  logic             clk,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output region_t          region,
    output logic             wrap
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        wrap    = count_q == CNT_W'(TOTAL - 1);
        count_d = clear ? '0 : !enable ? count_q : wrap ? '0 : count_q + 1'b1;
        region  = count_q < CNT_W'(ACTIVE)             ? REG_ACTIVE :
                  count_q < CNT_W'(ACTIVE + FP)        ? REG_FP     :
                  count_q < CNT_W'(ACTIVE + FP + SYNC) ? REG_SYNC   : REG_BP;
    end

    assign count = count_q;

    always_ff @(posedge clk) count_q <= count_d;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing (syncs, DE, X/Y, next-line fetch) held idle until DAC init is done.
// Defining COLOR_BAR_EN adds registered Red/Green/Blue outputs carrying 8 vertical colour bars.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic HS_POL   = DEF_HS_POL,
    parameter logic VS_POL   = DEF_VS_POL,
    parameter int   CNT_W    = DEF_CNT_W
)(
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Init_done,
    output logic             HSync,
    output logic             VSync,
    output logic             DE,
    output logic [CNT_W-1:0] X,
    output logic [CNT_W-1:0] Y,
    output logic             Frame_start,
    output logic             Line_fetch,
    output logic [CNT_W-1:0] Fetch_line
`ifdef COLOR_BAR_EN
    ,
    output logic [7:0]       Red,
    output logic [7:0]       Green,
    output logic [7:0]       Blue
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (longint'(H_TOTAL) > (64'd1 << CNT_W) || longint'(V_TOTAL) > (64'd1 << CNT_W)) begin : g_width_check
        $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CNT_W bits");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] h_cnt, v_cnt;
    region_t          h_reg, v_reg;
    logic             h_last, v_last, running, cnt_clear, frame_end;
    logic             hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d, lf_q, lf_d;
    logic [CNT_W-1:0] x_q, x_d, y_q, y_d, fl_q, fl_d;

    assign running   = state_q != WAIT_INIT;
    assign cnt_clear = !Reset_n || !running;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CNT_W(CNT_W)
    ) u_h (
        .clk(Clk), .clear(cnt_clear), .enable(running),
        .count(h_cnt), .region(h_reg), .wrap(h_last)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CNT_W(CNT_W)
    ) u_v (
        .clk(Clk), .clear(cnt_clear), .enable(running && h_last),
        .count(v_cnt), .region(v_reg), .wrap(v_last)
    );

    // A frame in progress always completes; idling is only re-entered at the frame boundary.
    always_comb begin
        frame_end = h_last && v_last;
        state_d   = Init_done ? RUN : (state_q == WAIT_INIT || frame_end) ? WAIT_INIT : DRAIN;
        de_d      = running && h_reg == REG_ACTIVE && v_reg == REG_ACTIVE;
        hs_d      = h_reg == REG_SYNC ? HS_POL : ~HS_POL;
        vs_d      = v_reg == REG_SYNC ? VS_POL : ~VS_POL;
        x_d       = de_d ? h_cnt : x_q;
        y_d       = de_d ? v_cnt : y_q;
        fs_d      = running && h_cnt == '0 && v_cnt == '0;
        lf_d      = running && h_cnt == CNT_W'(H_ACTIVE) && (v_last || v_cnt < CNT_W'(V_ACTIVE - 1));
        fl_d      = !lf_d ? fl_q : v_last ? '0 : v_cnt + 1'b1;
    end

`ifdef COLOR_BAR_EN
    logic [2:0]  bar;
    logic [23:0] rgb_q, rgb_d;

    // Bar index bits select which primaries are off: bit1 kills red, bit2 green, bit0 blue.
    always_comb begin
        bar   = 3'(h_cnt / CNT_W'(H_ACTIVE / 8));
        rgb_d = de_d ? {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}} : '0;
    end

    assign {Red, Green, Blue} = rgb_q;
`endif

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= WAIT_INIT;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            de_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            fs_q    <= 1'b0;
            lf_q    <= 1'b0;
            fl_q    <= '0;
`ifdef COLOR_BAR_EN
            rgb_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            de_q    <= de_d;
            x_q     <= x_d;
            y_q     <= y_d;
            fs_q    <= fs_d;
            lf_q    <= lf_d;
            fl_q    <= fl_d;
`ifdef COLOR_BAR_EN
            rgb_q   <= rgb_d;
`endif
        end
    end

    assign HSync       = hs_q;
    assign VSync       = vs_q;
    assign DE          = de_q;
    assign X           = x_q;
    assign Y           = y_q;
    assign Frame_start = fs_q;
    assign Line_fetch  = lf_q;
    assign Fetch_line  = fl_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized bench for vga_timing_gen against a frame-position reference model.
// Uses a scaled-down raster so whole frames fit the cycle budget; COLOR_BAR_EN adds the colour checks.
module tb_vga_timing_gen;

    localparam int HA = 16, HFP = 2, HS = 4, HBP = 3, HT = HA + HFP + HS + HBP;
    localparam int VA = 8,  VFP = 2, VS = 2, VBP = 3, VT = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;
    localparam int CW = 12;
    localparam int VW = 65;
    localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                         24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          init = 1'b0;
    logic          HSync, VSync, DE, Frame_start, Line_fetch;
    logic [CW-1:0] X, Y, Fetch_line;
    logic [23:0]   got_rgb;
    int            checks = 0;
    int            fails = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(CW)
    ) dut (
        .Clk(clk), .Reset_n(rst_n), .Init_done(init),
        .HSync(HSync), .VSync(VSync), .DE(DE), .X(X), .Y(Y),
        .Frame_start(Frame_start), .Line_fetch(Line_fetch), .Fetch_line(Fetch_line)
`ifdef COLOR_BAR_EN
        , .Red(got_rgb[23:16]), .Green(got_rgb[15:8]), .Blue(got_rgb[7:0])
`endif
    );

`ifndef COLOR_BAR_EN
    assign got_rgb = '0;
`endif

    // Reference model: a frame position p = v*HT + h and whether the raster is alive.
    bit            m_alive;
    int            m_p, mh, mv;
    logic          mde, mlf;
    logic          e_hs, e_vs, e_de, e_fs, e_lf;
    logic [CW-1:0] e_x, e_y, e_fl;
    logic [23:0]   e_rgb;

    always_comb begin
        mh  = m_p % HT;
        mv  = m_p / HT;
        mde = m_alive && mh < HA && mv < VA;
        mlf = m_alive && mh == HA && (mv == VT - 1 || mv < VA - 1);
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            m_alive <= 1'b0;
            m_p     <= 0;
            {e_hs, e_vs, e_de, e_fs, e_lf} <= 5'b11000;
            e_x     <= '0;
            e_y     <= '0;
            e_fl    <= '0;
            e_rgb   <= '0;
        end else begin
            e_de <= mde;
            e_hs <= !(mh >= HA + HFP && mh < HA + HFP + HS);
            e_vs <= !(mv >= VA + VFP && mv < VA + VFP + VS);
            e_fs <= m_alive && m_p == 0;
            e_lf <= mlf;
            if (mde) begin
                e_x <= CW'(mh);
                e_y <= CW'(mv);
            end
            if (mlf) e_fl <= (mv == VT - 1) ? '0 : CW'(mv + 1);
`ifdef COLOR_BAR_EN
            e_rgb <= mde ? BARS[mh / (HA / 8)] : 24'h0;
`else
            e_rgb <= 24'h0;
`endif
            if (m_alive) begin
                m_p <= (m_p + 1) % FRAME;
                if (m_p == FRAME - 1 && !init) m_alive <= 1'b0;
            end else begin
                m_alive <= init;
            end
        end
    end

    logic [VW-1:0] got_v, exp_v, rst_v;
    assign got_v = {HSync, VSync, DE, X, Y, Frame_start, Line_fetch, Fetch_line, got_rgb};
    assign exp_v = {e_hs, e_vs, e_de, e_x, e_y, e_fs, e_lf, e_fl, e_rgb};
    assign rst_v = {1'b1, 1'b1, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0, 12'd0, 24'd0};

    task automatic test_reset();
        int n = $urandom_range(150, 300);
        rst_n = 1'b0;
        init  = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (got_v !== rst_v) begin
            fails++;
            $display("FAIL reset_values: got %h expected %h", got_v, rst_v);
        end
        rst_n = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checks++;
            if (got_v !== exp_v) begin
                fails++;
                $display("FAIL idle_vec: got %h expected %h", got_v, exp_v);
            end
            checks++;
            if ({DE, HSync, VSync, Frame_start, Line_fetch} !== 5'b01100) begin
                fails++;
                $display("FAIL idle_outputs: got %b expected 01100", {DE, HSync, VSync, Frame_start, Line_fetch});
            end
        end
    endtask

    task automatic test_startup();
        int  n = 0, de_cnt = 0, hs_cnt = 0, de_fall = -1, hs_rise = -1;
        bit  found = 0;
        init = 1'b1;
        for (int i = 0; i < 5 && !found; i++) begin
            @(negedge clk);
            n++;
            found = Frame_start === 1'b1;
            checks++;
            if (got_v !== exp_v) begin
                fails++;
                $display("FAIL startup_vec: got %h expected %h", got_v, exp_v);
            end
        end
        checks++;
        if (!found || n != 2) begin
            fails++;
            $display("FAIL startup_latency: got %0d cycles (found=%0d) expected 2", n, found);
        end
        checks++;
        if ({DE, X, Y} !== {1'b1, 12'd0, 12'd0}) begin
            fails++;
            $display("FAIL first_pixel: got DE=%b X=%0d Y=%0d expected DE=1 X=0 Y=0", DE, X, Y);
        end
        for (int i = 0; i < HT; i++) begin
            if (i > 0) @(negedge clk);
            if (DE) de_cnt++;
            if (!DE && de_fall < 0) de_fall = i;
            if (!HSync) begin
                hs_cnt++;
                if (hs_rise < 0) hs_rise = i;
            end
            checks++;
            if (got_v !== exp_v) begin
                fails++;
                $display("FAIL line_vec: got %h expected %h", got_v, exp_v);
            end
        end
        checks++;
        if (de_cnt != HA || hs_cnt != HS || hs_rise - de_fall != HFP) begin
            fails++;
            $display("FAIL line_shape: got de=%0d hs=%0d gap=%0d expected de=%0d hs=%0d gap=%0d",
                     de_cnt, hs_cnt, hs_rise - de_fall, HA, HS, HFP);
        end
    endtask

    task automatic test_frames();
        bit found = 0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            @(negedge clk);
            found = Frame_start === 1'b1;
            checks++;
            if (got_v !== exp_v) begin
                fails++;
                $display("FAIL frame_sync_vec: got %h expected %h", got_v, exp_v);
            end
        end
        checks++;
        if (!found) begin
            fails++;
            $display("FAIL frame_sync_timeout: got no Frame_start expected one within %0d", 2 * FRAME);
        end
        for (int f = 0; f < 2; f++) begin
            int vs_cnt = 0, lf_cnt = 0, de_cnt = 0, fs_cnt = 0, last_lf = -1, first_fl = -1;
            logic [CW-1:0] last_fl = '1;
            for (int i = 0; i < FRAME; i++) begin
                if (!VSync) vs_cnt++;
                if (DE) de_cnt++;
                if (Frame_start) fs_cnt++;
                if (Line_fetch) begin
                    lf_cnt++;
                    last_lf = i;
                    last_fl = Fetch_line;
                    if (first_fl < 0) first_fl = int'(Fetch_line);
                end
                checks++;
                if (got_v !== exp_v) begin
                    fails++;
                    $display("FAIL frame_vec: got %h expected %h", got_v, exp_v);
                end
                @(negedge clk);
            end
            checks++;
            if (vs_cnt != VS * HT || de_cnt != HA * VA || fs_cnt != 1 || lf_cnt != VA) begin
                fails++;
                $display("FAIL frame_counts: got vs=%0d de=%0d fs=%0d lf=%0d expected vs=%0d de=%0d fs=1 lf=%0d",
                         vs_cnt, de_cnt, fs_cnt, lf_cnt, VS * HT, HA * VA, VA);
            end
            checks++;
            if (last_lf != (VT - 1) * HT + HA || last_fl !== 12'd0 || first_fl != 1) begin
                fails++;
                $display("FAIL frame_fetch: got last_at=%0d last_row=%0d first_row=%0d expected last_at=%0d last_row=0 first_row=1",
                         last_lf, last_fl, first_fl, (VT - 1) * HT + HA);
            end
            checks++;
            if (Frame_start !== 1'b1) begin
                fails++;
                $display("FAIL frame_period: got Frame_start=%b expected 1 after %0d cycles", Frame_start, FRAME);
            end
        end
    endtask

    task automatic test_drain();
        int k = $urandom_range(1, VA - 1) * HT + $urandom_range(0, HT - 1);
        int last_de = -1, fs_cnt = 0, late_de = 0;
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            checks++;
            if (got_v !== exp_v) begin
                fails++;
                $display("FAIL drain_pre_vec: got %h expected %h", got_v, exp_v);
            end
        end
        init = 1'b0;
        for (int i = 0; i < FRAME + 50; i++) begin
            if (DE) last_de = i;
            if (Frame_start) fs_cnt++;
            if (DE && i > FRAME - k) late_de++;
            checks++;
            if (got_v !== exp_v) begin
                fails++;
                $display("FAIL drain_vec: got %h expected %h", got_v, exp_v);
            end
            @(negedge clk);
        end
        checks++;
        if (last_de != (VA - 1) * HT + HA - 1 - k || fs_cnt != 0 || late_de != 0) begin
            fails++;
            $display("FAIL drain_completion: got last_de=%0d fs=%0d late_de=%0d expected last_de=%0d fs=0 late_de=0",
                     last_de, fs_cnt, late_de, (VA - 1) * HT + HA - 1 - k);
        end
    endtask

    task automatic test_reenable();
        int  d1 = $urandom_range(HT, 5 * HT);
        int  d2 = $urandom_range(5, 3 * HT);
        int  gap = -1;
        bit  found = 0;
        init = 1'b1;
        for (int i = 0; i < 5 && !found; i++) begin
            @(negedge clk);
            found = Frame_start === 1'b1;
        end
        checks++;
        if (!found) begin
            fails++;
            $display("FAIL reenable_start: got no Frame_start expected one within 5 cycles");
        end
        for (int i = 1; i < 2 * FRAME && gap < 0; i++) begin
            if (i == d1) init = 1'b0;
            if (i == d1 + d2) init = 1'b1;
            @(negedge clk);
            if (Frame_start) gap = i;
            checks++;
            if (got_v !== exp_v) begin
                fails++;
                $display("FAIL reenable_vec: got %h expected %h", got_v, exp_v);
            end
        end
        checks++;
        if (gap != FRAME) begin
            fails++;
            $display("FAIL reenable_period: got %0d expected %0d", gap, FRAME);
        end
    endtask

    task automatic test_random_toggle();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 149) == 0) init = ~init;
            @(negedge clk);
            checks++;
            if (got_v !== exp_v) begin
                fails++;
                $display("FAIL random_vec: got %h expected %h", got_v, exp_v);
            end
        end
    endtask

    task automatic test_mid_reset();
        int  k = $urandom_range(2, VA - 1) * HT + $urandom_range(1, HA - 1);
        int  n = 0;
        bit  found = 0;
        init = 1'b1;
        for (int i = 0; i < 2 * FRAME + 5 && !found; i++) begin
            @(negedge clk);
            found = Frame_start === 1'b1;
        end
        checks++;
        if (!found) begin
            fails++;
            $display("FAIL mid_reset_sync: got no Frame_start expected one within %0d", 2 * FRAME + 5);
        end
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            checks++;
            if (got_v !== exp_v) begin
                fails++;
                $display("FAIL mid_reset_pre_vec: got %h expected %h", got_v, exp_v);
            end
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (got_v !== rst_v) begin
            fails++;
            $display("FAIL mid_reset_values: got %h expected %h", got_v, rst_v);
        end
        rst_n = 1'b1;
        found = 0;
        for (int i = 0; i < 5 && !found; i++) begin
            @(negedge clk);
            n++;
            found = Frame_start === 1'b1;
        end
        checks++;
        if (!found || n != 2) begin
            fails++;
            $display("FAIL mid_reset_restart: got %0d cycles (found=%0d) expected 2", n, found);
        end
    endtask

`ifdef COLOR_BAR_EN
    task automatic test_color_bars();
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (DE && (X == 0 || X == HA / 8 || X == 7 * HA / 8)) begin
                logic [23:0] want;
                want = (X == 0) ? 24'hFFFFFF : (X == HA / 8) ? 24'hFFFF00 : 24'h000000;
                checks++;
                if (got_rgb !== want) begin
                    fails++;
                    $display("FAIL color_bar: got %h at X=%0d expected %h", got_rgb, X, want);
                end
            end else if (!DE) begin
                checks++;
                if (got_rgb !== 24'h0) begin
                    fails++;
                    $display("FAIL color_blank: got %h expected 000000", got_rgb);
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_startup();
        test_frames();
        test_drain();
        test_reenable();
        test_random_toggle();
        test_mid_reset();
`ifdef COLOR_BAR_EN
        test_color_bars();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish before 2000000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
